// File: rtl/piso_pkg.sv
// -----------------------------------------------------------------------------
// piso_pkg
// Shared constants for the parallel-in / serial-out serializer family.
//
// Contents:
//   PISO_N_DEFAULT : default parallel word width, reused by other serializers
//                    so they agree on one word size without repeating it.
// -----------------------------------------------------------------------------
package piso_pkg;

  localparam int unsigned PISO_N_DEFAULT = 4;

endpackage : piso_pkg

// File: rtl/piso_shift_reg.sv
// -----------------------------------------------------------------------------
// piso_shift_reg
// N-bit parallel-in, serial-out shift register. A parallel word is captured
// on a clock edge while en_in is high. While en_in is low, the word shifts out
// one bit per clock on q_out, and zeros fill in behind it. There is no
// handshake: the upstream block decides when to load. A load during a shift
// abandons whatever bits have not yet been sent.
//
// Build option:
//   PISO_MSB_FIRST_EN : when defined, bits go out MSB-first
//                       (q_out = sr[N-1], shift left, zero fill at the LSB).
//                       When undefined (the default), bits go out LSB-first
//                       (q_out = sr[0], shift right, zero fill at the MSB).
//
// Parameters:
//   N            : parallel word / register width (must be >= 2)
//
// Ports:
//   clk          : in  1 : rising-edge clock, the only clock domain
//   reset_al_in  : in  1 : async active-low reset; clears the register at once
//   en_in        : in  1 : 1 = load d_in on the next edge, 0 = shift
//   d_in         : in  N : parallel data word, sampled only while en_in = 1
//   q_out        : out 1 : serial data, driven straight from a register bit
// -----------------------------------------------------------------------------
module piso_shift_reg
  import piso_pkg::*;
#(
  parameter int unsigned N = PISO_N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_al_in,
  input  logic         en_in,
  input  logic [N-1:0] d_in,
  output logic         q_out
);

  logic [N-1:0] r_sr;
  logic [N-1:0] w_sr_next;

  // Next-state selection: a load takes priority over a shift.
  always_comb begin
    // NOTE: give every always_comb output a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    w_sr_next = r_sr;
    if (en_in) begin
      w_sr_next = d_in;
    end else begin
`ifdef PISO_MSB_FIRST_EN
      w_sr_next = {r_sr[N-2:0], 1'b0};
`else
      w_sr_next = {1'b0, r_sr[N-1:1]};
`endif
    end
  end

  // The reset is in the sensitivity list, so it clears the register
  // immediately, even in the middle of a shift.
  always_ff @(posedge clk or negedge reset_al_in) begin
    // NOTE: use non-blocking (<=) for every flop, so all state updates
    // together at the edge, whatever order the blocks are evaluated in.
    if (!reset_al_in) begin
      r_sr <= '0;
    end else begin
      r_sr <= w_sr_next;
    end
  end

  // The output comes straight from a flop bit, so there is no combinational
  // path from any input to q_out.
`ifdef PISO_MSB_FIRST_EN
  assign q_out = r_sr[N-1];
`else
  assign q_out = r_sr[0];
`endif

endmodule : piso_shift_reg

// File: tb/tb_piso_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_piso_shift_reg
// Directed bench for piso_shift_reg (N = 4). Inputs change on the falling edge
// of clk. q_out is checked on the falling edge that follows each rising edge.
// Expected serial sequences are written out by hand for both bit orders.
// Select the MSB-first set by defining PISO_MSB_FIRST_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_piso_shift_reg;

  localparam int N = 4;

  logic         clk;
  logic         reset_al_in;
  logic         en_in;
  logic [N-1:0] d_in;
  logic         q_out;

  int n_cmp = 0;
  int n_err = 0;

  piso_shift_reg #(.N(N)) dut (
    .clk         (clk),
    .reset_al_in (reset_al_in),
    .en_in       (en_in),
    .d_in        (d_in),
    .q_out       (q_out)
  );

  // Period 20: rising edges at 10, 30, 50, ...; falling edges at 20, 40, ...
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input logic exp, input string tag);
    n_cmp++;
    assert (q_out === exp)
    else begin
      n_err++;
      $error("FAIL %s: q_out=%b expected=%b", tag, q_out, exp);
    end
  endtask

  // Drive the inputs (the caller is at a falling edge), let one rising edge
  // pass, then check q_out on the next falling edge.
  task automatic step(input logic en, input logic [N-1:0] d,
                      input logic exp, input string tag);
    en_in = en;
    d_in  = d;
    @(negedge clk);
    check(exp, tag);
  endtask

  // Expected q_out sequences. Element 0 is the value right after the load edge.
`ifdef PISO_MSB_FIRST_EN
  localparam logic [7:0] SEQ_1011 = 8'b0000_1101; // 1,0,1,1,0...
  localparam logic [7:0] SEQ_1101 = 8'b0000_1011; // 1,1,0,1,0...
`else
  localparam logic [7:0] SEQ_1011 = 8'b0000_1011; // 1,1,0,1,0...
  localparam logic [7:0] SEQ_1101 = 8'b0000_1101; // 1,0,1,1,0...
`endif

  task automatic load_and_drain(input logic [N-1:0] d, input logic [7:0] seq,
                                input string tag);
    step(1'b1, d, seq[0], $sformatf("%s_load", tag));
    for (int i = 1; i < 8; i++)
      step(1'b0, d, seq[i], $sformatf("%s_sh%0d", tag, i));
  endtask

  initial begin
    // 1. Reset held low for 25 time units.
    reset_al_in = 1'b0;
    en_in       = 1'b0;
    d_in        = '0;
    #5;
    check(1'b0, "rst_t5");
    #15;                              // t = 20, falling edge, after one rising edge
    check(1'b0, "rst_t20");
    #5;                               // t = 25
    reset_al_in = 1'b1;
    @(negedge clk);                   // t = 40
    check(1'b0, "post_rst_idle0");
    step(1'b0, 4'b0000, 1'b0, "post_rst_idle1");

    // 2. Load 1011, then shift the word out.
    load_and_drain(4'b1011, SEQ_1011, "w1011");

    // Idle. d_in changes while en_in is low must be ignored.
    step(1'b0, 4'b1111, 1'b0, "idle_d_ignored0");
    step(1'b0, 4'b0101, 1'b0, "idle_d_ignored1");

    // 3. Load 1101.
    load_and_drain(4'b1101, SEQ_1101, "w1101");

    // en_in held high reloads every cycle; q_out follows the latest word.
`ifdef PISO_MSB_FIRST_EN
    step(1'b1, 4'b0001, 1'b0, "reload_a");
    step(1'b1, 4'b1110, 1'b1, "reload_b");
    step(1'b0, 4'b0000, 1'b1, "reload_sh1");
    step(1'b0, 4'b0000, 1'b1, "reload_sh2");
    step(1'b0, 4'b0000, 1'b0, "reload_sh3");
`else
    step(1'b1, 4'b0001, 1'b1, "reload_a");
    step(1'b1, 4'b1110, 1'b0, "reload_b");
    step(1'b0, 4'b0000, 1'b1, "reload_sh1");
    step(1'b0, 4'b0000, 1'b1, "reload_sh2");
    step(1'b0, 4'b0000, 1'b1, "reload_sh3");
    step(1'b0, 4'b0000, 1'b0, "reload_sh4");
`endif

    // 4. Load 1111, shift twice, then assert reset between clock edges.
    step(1'b1, 4'b1111, 1'b1, "r1111_load");
    step(1'b0, 4'b1111, 1'b1, "r1111_sh1");
    step(1'b0, 4'b1111, 1'b1, "r1111_sh2");
    #3;
    reset_al_in = 1'b0;
    #1;                               // still well before the next rising edge
    check(1'b0, "async_rst_immediate");
    @(negedge clk);
    check(1'b0, "async_rst_held");
    reset_al_in = 1'b1;
    step(1'b0, 4'b1010, 1'b0, "after_rst0");
    step(1'b0, 4'b1010, 1'b0, "after_rst1");

    // 5. Load 0011, shift once, then load 1000 mid-shift.
`ifdef PISO_MSB_FIRST_EN
    step(1'b1, 4'b0011, 1'b0, "ov_load_a");
    step(1'b0, 4'b0011, 1'b0, "ov_sh_a");
    step(1'b1, 4'b1000, 1'b1, "ov_load_b");
    step(1'b0, 4'b1000, 1'b0, "ov_sh1");
    step(1'b0, 4'b1000, 1'b0, "ov_sh2");
    step(1'b0, 4'b1000, 1'b0, "ov_sh3");
    step(1'b0, 4'b1000, 1'b0, "ov_sh4");
`else
    step(1'b1, 4'b0011, 1'b1, "ov_load_a");
    step(1'b0, 4'b0011, 1'b1, "ov_sh_a");
    step(1'b1, 4'b1000, 1'b0, "ov_load_b");
    step(1'b0, 4'b1000, 1'b0, "ov_sh1");
    step(1'b0, 4'b1000, 1'b0, "ov_sh2");
    step(1'b0, 4'b1000, 1'b1, "ov_sh3");
    step(1'b0, 4'b1000, 1'b0, "ov_sh4");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_piso_shift_reg

// File: doc/piso_shift_reg.md
Name: piso_shift_reg

Overview:
- N-bit parallel-in, serial-out shift register.
- Captures a parallel word when enabled, then shifts it out one bit per clock on a single serial line.
- Used as a simple serializer between a parallel datapath and a one-wire serial sink.
- No handshake; the upstream block controls load timing through the enable input.

Parameters:
N, 4, width of the parallel input word and of the internal shift register (N >= 2).

Ports:
clk  input  1  rising-edge clock; only clock domain.
reset_al_in  input  1  asynchronous, active-low reset; clears all state immediately, deassertion is synchronous to clk.
en_in  input  1  parallel-load enable; high = load d_in, low = shift.
d_in  input  N  parallel data word, sampled on a rising clk edge while en_in is high.
q_out  output  1  serial data out; driven directly from the register's output bit (no combinational path from inputs).

Behaviour:
- State: N-bit register sr[N-1:0]. q_out = sr[0] (LSB-first by default).
- Reset: reset_al_in low forces sr = 0 asynchronously, so q_out = 0. Reset overrides load and shift at all times, including mid-shift.
- Load: on a rising clk edge with reset_al_in high and en_in high, sr <= d_in. q_out shows d_in[0] right after that edge (1-cycle latency from sample to first bit).
- en_in held high for several cycles reloads d_in every cycle; q_out stays at d_in[0] of the latest word.
- Shift: on a rising clk edge with reset_al_in high and en_in low, sr <= {1'b0, sr[N-1:1]}.
  - Zeros fill from the MSB.
  - After load, q_out over consecutive shift edges is d_in[1], d_in[2], ..., d_in[N-1], then 0 indefinitely.
  - Full word on q_out = d_in[0..N-1] over N cycles, starting at the load edge.
- No wrap-around/rotation: bits shifted out are discarded.
- Load during an ongoing shift: the new word replaces the remaining bits immediately; no completion protection.
- d_in changes while en_in is low are ignored.
- Reset release: sr stays 0 until the first load.

Optional Feature:
Macro PISO_MSB_FIRST_EN.
- Defined: shift direction reversed.
  - q_out = sr[N-1].
  - Shift is sr <= {sr[N-2:0], 1'b0}.
  - Serial order is d_in[N-1] first, down to d_in[0], then zeros.
- Undefined (default): LSB-first behaviour as above.
- Reset, load priority and latency are identical in both builds.

Decomposition:
- No shared package needed.
- A small package (piso_pkg) may hold only the default width constant if other serializers reuse it.
- Single flat module; no sub-module is natural, because the register and its next-state mux are one always block.

Test Plan:
1. Hold reset_al_in low with en_in=0, d_in=0 for 25 time units, clk period 20 -> q_out=0 throughout. Release reset; q_out stays 0 with no load.
2. en_in=1, d_in=4'b1011 for one rising edge, then en_in=0 -> q_out = 1 (load edge), then 1, 0, 1 on the next three edges, then 0 on every later edge.
3. After an idle period, en_in=1, d_in=4'b1101 for one edge, then en_in=0 -> q_out sequence 1, 0, 1, 1, then 0s.
4. Load 4'b1111, shift two edges, assert reset_al_in low between clock edges -> q_out drops to 0 immediately, without waiting for a clk edge. Remains 0 after release until the next load.
5. Load 4'b0011, shift one edge, then load 4'b1000 -> q_out goes 1, 1, then 0 (new LSB), followed by 0, 0, 1, 0...; the old word is abandoned.
6. Build with PISO_MSB_FIRST_EN defined, load 4'b1011 -> q_out sequence 1, 0, 1, 1, then 0s.
